// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
// Shared constants for the store buffer and the hazard unit that probes it.
// The entry layout is {word address, lane-positioned data, byte strobes}.
// The hazard unit and store_buffer both read SB_DEPTH and the field widths
// from here, so they agree on the entry layout.
package store_buffer_pkg;

    localparam int SB_DEPTH  = 4;   // default number of store entries
    localparam int SB_AW     = 32;  // default byte-address width
    localparam int SB_DATA_W = 32;  // store data width
    localparam int SB_STRB_W = 4;   // one strobe per byte lane
    localparam int SB_OFS_W  = 2;   // byte-offset bits dropped from stored addresses

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if
// Bundles the store buffer's input, memory-write and load-probe signals.
//   slave  : store_buffer side (accepts stores, drives memory, answers probes)
//   master : environment side (MEM stage, data memory, hazard unit)
// Handshakes:
//   in_valid/in_ready : a store transfers in any cycle where both are high.
//                       in_ready does not depend on in_valid.
//   mem_req/mem_ack   : the head entry retires in any cycle where both are high.
//                       While mem_req is high and not acked, mem_addr, mem_wdata
//                       and mem_wstrb hold their values. An ack without a
//                       request is ignored.
interface store_buffer_if #(
    parameter int AW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_wdata;
    logic [3:0]    in_wstrb;

    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ack;

    logic          ld_check_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_conflict;

    logic          sb_empty;
    logic [CW-1:0] sb_count;

    modport slave (
        input  in_valid, in_addr, in_wdata, in_wstrb, mem_ack, ld_check_valid, ld_addr,
        output in_ready, mem_req, mem_addr, mem_wdata, mem_wstrb, ld_conflict,
               sb_empty, sb_count
    );

    modport master (
        output in_valid, in_addr, in_wdata, in_wstrb, mem_ack, ld_check_valid, ld_addr,
        input  in_ready, mem_req, mem_addr, mem_wdata, mem_wstrb, ld_conflict,
               sb_empty, sb_count
    );

endinterface

// File: rtl/store_buffer_match.sv
// sb_match
// Per-entry word-address comparator for load-hazard detection.
// Ports:
//   entry_word  in  DEPTH x WW  stored word addresses
//   entry_valid in  DEPTH       entry valid bits
//   probe_word  in  WW          word address of the probing load
//   hit         out DEPTH       one bit per valid entry whose word matches
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int WW    = SB_AW - SB_OFS_W
) (
    input  logic [DEPTH-1:0][WW-1:0] entry_word,
    input  logic [DEPTH-1:0]         entry_valid,
    input  logic [WW-1:0]            probe_word,
    output logic [DEPTH-1:0]         hit
);

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = entry_valid[i] && (entry_word[i] == probe_word);
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
// Posted-write FIFO between the byte-lane store generator and the data-memory
// write port. Stores retire in order over mem_req/mem_ack. Loads that hit a
// word with a pending store get ld_conflict, so the hazard unit can stall them.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   sb (slave) : in_*  store input handshake
//                mem_* head-entry write request to memory
//                ld_*  load probe / conflict flag
//                sb_empty, sb_count : registered occupancy status
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave sb
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = AW - SB_OFS_W;

    logic [PW-1:0]                      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                      count_q,  count_d;
    logic [DEPTH-1:0]                   valid_q,  valid_d;
    logic [DEPTH-1:0][WW-1:0]           word_q,   word_d;
    logic [DEPTH-1:0][SB_DATA_W-1:0]    data_q,   data_d;
    logic [DEPTH-1:0][SB_STRB_W-1:0]    strb_q,   strb_d;

    logic             full;
    logic             not_empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] hit;
    logic [WW-1:0]    in_word;
    logic [WW-1:0]    ld_word;
    logic             unused_ofs;

    assign in_word = sb.in_addr[AW-1:SB_OFS_W];
    assign ld_word = sb.ld_addr[AW-1:SB_OFS_W];
    // Byte offsets are irrelevant: entries and probes are word-granular.
    assign unused_ofs = ^{sb.in_addr[SB_OFS_W-1:0], sb.ld_addr[SB_OFS_W-1:0]};

    // Readiness comes only from registered count: a full buffer stays
    // not-ready even while the head is being acked.
    assign full      = (count_q == CW'(DEPTH));
    assign not_empty = (count_q != '0);
    assign accept    = sb.in_valid && !full;
    // A zero-strobe store completes its handshake but writes nothing, so it
    // never takes an entry.
    assign push      = accept && (sb.in_wstrb != '0);
    assign pop       = not_empty && sb.mem_ack;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        word_d   = word_q;
        data_d   = data_q;
        strb_d   = strb_q;

        // Push and pop never target the same slot: push needs count < DEPTH
        // and pop needs count > 0, so wr_ptr != rd_ptr or the slot is free.
        if (push) begin
            word_d[wr_ptr_q]  = in_word;
            data_d[wr_ptr_q]  = sb.in_wdata;
            strb_d[wr_ptr_q]  = sb.in_wstrb;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            word_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            word_q   <= word_d;
            data_q   <= data_d;
            strb_q   <= strb_d;
        end
    end

    // Memory side is driven purely from registers; a new store reaches
    // mem_req no earlier than the cycle after its push. Fields read as zero
    // while no request is pending.
    assign sb.mem_req   = not_empty;
    assign sb.mem_addr  = not_empty ? {word_q[rd_ptr_q], {SB_OFS_W{1'b0}}} : '0;
    assign sb.mem_wdata = not_empty ? data_q[rd_ptr_q] : '0;
    assign sb.mem_wstrb = not_empty ? strb_q[rd_ptr_q] : '0;
    assign sb.in_ready  = !full;
    assign sb.sb_empty  = !not_empty;
    assign sb.sb_count  = count_q;

    sb_match #(
        .DEPTH (DEPTH),
        .WW    (WW)
    ) u_match (
        .entry_word  (word_q),
        .entry_valid (valid_q),
        .probe_word  (ld_word),
        .hit         (hit)
    );

    // The head being popped this cycle is still valid in valid_q, so it still
    // flags a conflict (conservative). A same-cycle push also counts.
    assign sb.ld_conflict = sb.ld_check_valid &&
                            ((|hit) || (push && (in_word == ld_word)));

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the byte-lane store generator and the data-memory write port.
- Accepts an already-aligned store: word address, lane-positioned data and byte strobes.
- Retires stores to memory in order over a req/ack handshake, so the pipeline does not stall on memory write latency.
- Flags loads that hit a word with a pending store, so the hazard unit can stall them.

Parameters:
- DEPTH, 4, number of store entries; power of two, 2..16.
- AW, 32, address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  store presented by MEM stage.
- in_ready  out  1  buffer can accept a store this cycle.
- in_addr  in  AW  byte address of store.
- in_wdata  in  32  lane-positioned store data.
- in_wstrb  in  4  byte-lane write strobes.
- mem_req  out  1  head entry presented to memory.
- mem_addr  out  AW  word-aligned address of head entry.
- mem_wdata  out  32  head entry data.
- mem_wstrb  out  4  head entry strobes.
- mem_ack  in  1  memory accepted head entry this cycle.
- ld_check_valid  in  1  a load is probing the buffer.
- ld_addr  in  AW  load byte address.
- ld_conflict  out  1  load word matches a pending store.
- sb_empty  out  1  no pending entries (used for fence/drain).
- sb_count  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (async, rst_n low):
  - rd/wr pointers = 0; count = 0; all entry valid bits = 0.
  - Outputs: mem_req = 0, sb_empty = 1, sb_count = 0, in_ready = 1, ld_conflict = 0.
  - mem_addr/mem_wdata/mem_wstrb = 0.
- Storage: entry = {addr[AW-1:2], wdata, wstrb}. Stored mem_addr = {addr[AW-1:2], 2'b00}.
- Push (input side):
  - in_ready = (count != DEPTH). No same-cycle bypass: full stays not-ready even if mem_ack is high.
  - Push occurs when in_valid && in_ready.
  - A store with in_wstrb == 4'b0000 is accepted (handshake completes) but not enqueued.
- Memory side:
  - mem_req = (count != 0). mem_addr/wdata/wstrb come from the head entry's registers.
  - Pop occurs when mem_req && mem_ack. A mem_ack with mem_req low is ignored.
  - While mem_req is high and not acked, mem_* outputs must remain stable.
- Latency:
  - A store pushed in cycle N raises mem_req in N+1 at the earliest. There is no combinational path from input to memory.
  - A pop in cycle N presents the next entry, or drops mem_req, in N+1.
- Pointers and count:
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged. Push-only increments; pop-only decrements.
  - count never exceeds DEPTH and never underflows.
- Ordering: strict FIFO; no merging or coalescing of entries.
- ld_conflict (combinational), computed as ld_check_valid AND any of:
  - some valid entry has addr[AW-1:2] == ld_addr[AW-1:2];
  - a store is being pushed this cycle (in_valid && in_ready, wstrb != 0) with the same word address.
  - The head entry being popped this cycle still counts (conservative).
  - Byte-lane overlap is not considered.
- Status outputs:
  - sb_empty = (count == 0), registered-derived.
  - sb_count is the registered count.
- Reset mid-operation discards all pending entries; this is not an error.

Decomposition:
- Shared constants header: entry field widths and the SB_DEPTH default, so the hazard unit and store_buffer agree.
- One natural sub-module, sb_match: a per-entry word-address comparator producing a DEPTH-bit hit vector, OR-reduced in store_buffer.
- FIFO control stays in store_buffer.

Test Plan:
- Reset then idle → mem_req=0, sb_empty=1, in_ready=1, sb_count=0.
- Push addr 0x1002, wdata 0x00AB0000, wstrb 0100, mem_ack held 0 → next cycle mem_req=1, mem_addr=0x1000, mem_wstrb=0100; outputs stable for 5 cycles; ack → sb_empty=1 next cycle.
- Push 4 stores (0x10, 0x14, 0x18, 0x1C), no ack → in_ready=0 after the 4th. Then ack every cycle while in_valid stays high → drain in order 0x10, 0x14, 0x18, 0x1C; in_ready reasserts one cycle after the first pop.
- Buffer at count=2, simultaneous push and ack → sb_count stays 2; order preserved; pointer wrap exercised over 10 cycles of continuous push/ack.
- Pending store at 0x200; load at 0x203 → ld_conflict=1. Load at 0x204 → 0. Same-cycle push to 0x204 with load 0x204 → 1.
- Push with wstrb=0000 → in_ready handshake completes, sb_count unchanged. Assert rst_n low with 3 entries pending → mem_req=0 and sb_count=0 immediately.
